fpu_issue_arb: RTL and testbench

Round-robin issue arbiter and pipeline sequencer for the shared floating-point datapath. Up to NUM_REQ requesters compete for one fixed-latency PIPE_LEN-stage FPU pipeline whose registers share a single global clock enable. The block grants one requester per cycle, drives the operand-mux select and the pipeline enable, and tracks valid bits and requester IDs alongside the data. It also presents completed results through a valid/ready handshake with full-pipeline backpressure.

---
 rtl/fpu_issue_arb.sv | 79 +++++++
 tb/tb_fpu_issue_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_arb.sv
// Round-robin issue arbiter and valid/ID sequencer for the shared FPU pipeline.
// One global enable stalls the whole pipe when the output result is held.
module fpu_issue_arb #(
  parameter  int NUM_REQ  = 4,
  parameter  int PIPE_LEN = 3,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int CNTW     = $clog2(PIPE_LEN + 1)
) (
  input  logic               I_Clk,
  input  logic               I_nReset,
  input  logic [NUM_REQ-1:0] I_Req,
  input  logic               I_Flush,
  output logic [NUM_REQ-1:0] O_Gnt,
  output logic [IDW-1:0]     O_GntIdx,
  output logic               O_PipeEn,
  output logic               O_OutValid,
  output logic [IDW-1:0]     O_OutId,
  input  logic               I_OutReady,
  output logic [CNTW-1:0]    O_Count
);

  logic [PIPE_LEN-1:0] vld_p;
  logic [IDW-1:0]      id_p [PIPE_LEN];
  logic [IDW-1:0]      ptr;
  logic                pipe_en;
  logic                found;
  logic [IDW-1:0]      gnt_idx;
  int unsigned         scan;

  assign pipe_en  = ~vld_p[PIPE_LEN-1] | I_OutReady;
  assign O_PipeEn = pipe_en;

  // Arbitration: first request at or after ptr, wrapping at NUM_REQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    if (pipe_en && !I_Flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = (int'(ptr) + k) % NUM_REQ;
        if (!found && I_Req[scan]) begin
          found   = 1'b1;
          gnt_idx = IDW'(scan);
        end
      end
    end
  end

  assign O_Gnt    = found ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign O_GntIdx = gnt_idx;

  // Stage 0 .. PIPE_LEN-1: valid and ID travel with the datapath registers.
  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      vld_p <= '0;
      ptr   <= '0;
      for (int i = 0; i < PIPE_LEN; i++) id_p[i] <= '0;
    end else if (I_Flush) begin
      vld_p <= '0;
    end else if (pipe_en) begin
      for (int i = PIPE_LEN - 1; i > 0; i--) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
      vld_p[0] <= found;
      id_p[0]  <= gnt_idx;
      if (found) ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign O_OutValid = vld_p[PIPE_LEN-1];
  assign O_OutId    = id_p[PIPE_LEN-1];

  always_comb begin
    O_Count = '0;
    for (int i = 0; i < PIPE_LEN; i++) O_Count = O_Count + CNTW'(vld_p[i]);
  end

endmodule

// File: tb/tb_fpu_issue_arb.sv
// Scoreboard bench for fpu_issue_arb: 4x3 instance driven by a reference model,
// plus a 2x1 instance exercised with directed checks.
module tb_fpu_issue_arb;
  localparam int NR = 4;
  localparam int PL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst;
  logic [NR-1:0] req;
  logic          flush;
  logic          rdy;
  logic [NR-1:0] gnt;
  logic [1:0]    gidx;
  logic          pen;
  logic          ov;
  logic [1:0]    oid;
  logic [1:0]    cnt;

  logic [1:0] req1;
  logic       flush1;
  logic       rdy1;
  logic [1:0] gnt1;
  logic [0:0] gidx1;
  logic       pen1;
  logic       ov1;
  logic [0:0] oid1;
  logic [0:0] cnt1;

  fpu_issue_arb #(.NUM_REQ(NR), .PIPE_LEN(PL)) u_dut (
    .I_Clk(clk), .I_nReset(nrst), .I_Req(req), .I_Flush(flush),
    .O_Gnt(gnt), .O_GntIdx(gidx), .O_PipeEn(pen), .O_OutValid(ov),
    .O_OutId(oid), .I_OutReady(rdy), .O_Count(cnt)
  );

  fpu_issue_arb #(.NUM_REQ(2), .PIPE_LEN(1)) u_dut1 (
    .I_Clk(clk), .I_nReset(nrst), .I_Req(req1), .I_Flush(flush1),
    .O_Gnt(gnt1), .O_GntIdx(gidx1), .O_PipeEn(pen1), .O_OutValid(ov1),
    .O_OutId(oid1), .I_OutReady(rdy1), .O_Count(cnt1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { int id; int age; } op_t;
  op_t sb[$];
  int  mptr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the 4x3 instance: drive, check against the model, clock, update model.
  task automatic cycle(input logic [NR-1:0] r, input logic rd, input logic fl);
    logic front_v;
    logic en;
    logic hit;
    int   gi;
    req = r; rdy = rd; flush = fl;
    #2;
    front_v = (sb.size() > 0) && (sb[0].age == PL);
    en      = !front_v || rd;
    hit     = 1'b0;
    gi      = 0;
    if (en && !fl)
      for (int k = 0; k < NR; k++)
        if (!hit && r[(mptr + k) % NR]) begin
          hit = 1'b1;
          gi  = (mptr + k) % NR;
        end
    check_val("pipe_en", pen, en);
    check_val("gnt", gnt, hit ? (1 << gi) : 0);
    check_val("gnt_idx", gidx, gi);
    check_val("out_valid", ov, front_v);
    if (front_v) check_val("out_id", oid, sb[0].id);
    check_val("count", cnt, sb.size());
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else if (en) begin
      if (front_v) void'(sb.pop_front());
      foreach (sb[i]) sb[i].age++;
      if (hit) begin
        sb.push_back('{gi, 1});
        mptr = (gi + 1) % NR;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_pen"}, pen, 1);
    check_val({tag, "_cnt"}, cnt, 0);
    check_val({tag, "_ov"}, ov, 0);
    check_val({tag, "_oid"}, oid, 0);
    check_val({tag, "_gnt"}, gnt, 0);
  endtask

  initial begin
    nrst = 1'b0; req = '0; flush = 1'b0; rdy = 1'b1;
    req1 = '0; flush1 = 1'b0; rdy1 = 1'b1;
    mptr = 0;
    #12;
    check_reset_vals("rst");
    @(posedge clk);
    #1 nrst = 1'b1;

    // Full request set: grants 0,1,2,3, results come out in the same order.
    repeat (4) cycle(4'hF, 1'b1, 1'b0);
    repeat (3) cycle(4'h0, 1'b1, 1'b0);

    // Pointer moves to 2, then wraps over requests 0 and 1.
    cycle(4'b0010, 1'b1, 1'b0);
    repeat (3) cycle(4'b0011, 1'b1, 1'b0);
    repeat (3) cycle(4'h0, 1'b1, 1'b0);

    // Fill the pipe with output held, stay stalled, then release.
    repeat (3) cycle(4'hF, 1'b0, 1'b0);
    repeat (5) cycle(4'hF, 1'b0, 1'b0);
    repeat (4) cycle(4'hF, 1'b1, 1'b0);
    repeat (3) cycle(4'h0, 1'b1, 1'b0);

    // Flush with two in flight; requester 2 is granted the next cycle.
    repeat (2) cycle(4'hF, 1'b1, 1'b0);
    cycle(4'b0100, 1'b1, 1'b1);
    cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'hF, 1'b1, 1'b0);
    repeat (3) cycle(4'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with a full pipe.
    repeat (3) cycle(4'hF, 1'b1, 1'b0);
    check_val("pre_rst_cnt", cnt, 3);
    req = '0;
    #2 nrst = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    sb.delete();
    mptr = 0;
    #2 nrst = 1'b1;
    repeat (3) cycle(4'h0, 1'b1, 1'b0);
    cycle(4'hF, 1'b1, 1'b0);
    repeat (3) cycle(4'h0, 1'b1, 1'b0);

    // Single-stage instance: output one edge after grant, held while not ready.
    req1 = 2'b01; rdy1 = 1'b1;
    #2;
    check_val("p1_gnt0", gnt1, 2'b01);
    check_val("p1_ov_pre", ov1, 0);
    @(posedge clk);
    #1;
    check_val("p1_ov0", ov1, 1);
    check_val("p1_oid0", oid1, 0);
    check_val("p1_cnt0", cnt1, 1);
    req1 = 2'b10; rdy1 = 1'b0;
    #1;
    check_val("p1_pen_stall", pen1, 0);
    check_val("p1_gnt_stall", gnt1, 2'b00);
    @(posedge clk);
    #1;
    check_val("p1_ov_hold", ov1, 1);
    check_val("p1_oid_hold", oid1, 0);
    rdy1 = 1'b1;
    #1;
    check_val("p1_pen_go", pen1, 1);
    check_val("p1_gnt1", gnt1, 2'b10);
    @(posedge clk);
    #1;
    check_val("p1_ov1", ov1, 1);
    check_val("p1_oid1", oid1, 1);
    req1 = 2'b00;
    @(posedge clk);
    #1;
    check_val("p1_ov_idle", ov1, 0);
    check_val("p1_cnt_idle", cnt1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
